// File: rtl/bwzz_irq_pkg.sv
// Shared definitions for the interrupt sequencer.
//   irq_state_e   : FSM state encoding (IDLE/PENDING/ASSERT/SERVICE).
//   DefSyncStages : default synchroniser depth.
//   DefIntCycles  : default number of cycles interrupt is held high.
package bwzz_irq_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StPending = 2'b01,
        StAssert  = 2'b10,
        StService = 2'b11
    } irq_state_e;

    localparam int unsigned DefSyncStages = 2;
    localparam int unsigned DefIntCycles  = 3;

endpackage

// File: rtl/irq_sync_edge.sv
// Synchronises an asynchronous request and flags its rising edge.
// Ports:
//   clk      in  : clock, rising edge
//   rst      in  : synchronous active-low reset
//   irq_in   in  : asynchronous request
//   irq_edge out : one-cycle rising-edge flag, decoded from registers only
module irq_sync_edge
    import bwzz_irq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DefSyncStages
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    output logic irq_edge
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Chain and prev clear together, so a level held through reset reappears as an edge.
    assign irq_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_sequencer.sv
// Feeds the core's interrupt input: synchronises irq_in, holds a captured edge pending
// until the core is neither flushing nor stalled, then drives interrupt for INT_CYCLES
// cycles and blocks new requests until rti_done.
// Ports:
//   clk, rst            : clock; synchronous active-low reset
//   irq_in              : asynchronous external request (rising edge significant)
//   flush, stall        : core conditions that defer launch
//   rti_done            : core retired RTI; ends service
//   interrupt           : to core, high in ASSERT
//   int_start           : first ASSERT cycle only
//   pending             : request captured, not launched
//   int_busy            : ASSERT or SERVICE
//   drop_count          : saturating lost/merged edge count (IRQ_DROP_COUNT_EN only)
// Optional feature macro: IRQ_DROP_COUNT_EN.
module irq_sequencer
    import bwzz_irq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DefSyncStages,
    parameter int unsigned INT_CYCLES  = DefIntCycles
`ifdef IRQ_DROP_COUNT_EN
    ,
    parameter int unsigned DROP_W      = 8
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              irq_in,
    input  logic              flush,
    input  logic              stall,
    input  logic              rti_done,
    output logic              interrupt,
    output logic              int_start,
    output logic              pending,
`ifdef IRQ_DROP_COUNT_EN
    output logic              int_busy,
    output logic [DROP_W-1:0] drop_count
`else
    output logic              int_busy
`endif
);

    localparam int unsigned    StepW    = (INT_CYCLES > 1) ? $clog2(INT_CYCLES) : 1;
    localparam logic [StepW-1:0] StepInit = StepW'(INT_CYCLES - 1);

    logic             irq_edge;
    irq_state_e       state_q, state_d;
    logic [StepW-1:0] step_q, step_d;

    irq_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .irq_edge (irq_edge)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        unique case (state_q)
            StIdle: begin
                if (irq_edge) state_d = StPending;
            end
            StPending: begin
                if (!flush && !stall) begin
                    state_d = StAssert;
                    step_d  = StepInit;
                end
            end
            StAssert: begin
                if (step_q == '0) state_d = StService;
                else              step_d  = step_q - StepW'(1);
            end
            StService: begin
                // An edge coinciding with rti_done is kept rather than lost.
                if (rti_done) state_d = irq_edge ? StPending : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    assign interrupt = (state_q == StAssert);
    assign int_start = (state_q == StAssert) && (step_q == StepInit);
    assign pending   = (state_q == StPending);
    assign int_busy  = (state_q == StAssert) || (state_q == StService);

`ifdef IRQ_DROP_COUNT_EN
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              drop_event;

    always_comb begin
        drop_event = irq_edge && ((state_q == StPending) || (state_q == StAssert) ||
                                  ((state_q == StService) && !rti_done));
        drop_d     = drop_q;
        if (drop_event && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) drop_q <= '0;
        else      drop_q <= drop_d;
    end

    assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed self-checking bench for irq_sequencer (SYNC_STAGES=2, INT_CYCLES=3).
// Drop-counter checks are compiled only when IRQ_DROP_COUNT_EN is defined.
module tb_irq_sequencer;

    logic clk = 1'b0;
    logic rst, irq_in, flush, stall, rti_done;
    logic interrupt, int_start, pending, int_busy;
`ifdef IRQ_DROP_COUNT_EN
    logic [7:0] drop_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    irq_sequencer #(
        .SYNC_STAGES (2),
        .INT_CYCLES  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .flush      (flush),
        .stall      (stall),
        .rti_done   (rti_done),
        .interrupt  (interrupt),
        .int_start  (int_start),
        .pending    (pending),
`ifdef IRQ_DROP_COUNT_EN
        .int_busy   (int_busy),
        .drop_count (drop_count)
`else
        .int_busy   (int_busy)
`endif
    );

    // Advance past one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From the first ASSERT cycle: ride out ASSERT into SERVICE, then pulse rti_done.
    task automatic retire();
        repeat (4) tick();
        rti_done = 1'b1;
        tick();
        rti_done = 1'b0;
    endtask

    task automatic test_reset_and_latency();
        rst = 1'b0; irq_in = 1'b0; flush = 1'b0; stall = 1'b0; rti_done = 1'b0;
        tick(); tick();
        n_checks++; if ({interrupt, int_start, pending, int_busy} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 0000",
                               {interrupt, int_start, pending, int_busy});
        end
        rst = 1'b1; irq_in = 1'b1;
        tick(); tick();
        n_checks++; if (pending !== 1'b0) begin
            n_fail++; $display("FAIL lat_pending_e1: got %b want 0", pending);
        end
        tick();
        n_checks++; if ({pending, interrupt} !== 2'b10) begin
            n_fail++; $display("FAIL lat_pending_e2: got %b want 10", {pending, interrupt});
        end
        tick();
        n_checks++; if ({interrupt, int_start, pending, int_busy} !== 4'b1101) begin
            n_fail++; $display("FAIL lat_assert_e3: got %b want 1101",
                               {interrupt, int_start, pending, int_busy});
        end
        tick();
        n_checks++; if ({interrupt, int_start} !== 2'b10) begin
            n_fail++; $display("FAIL lat_assert_e4: got %b want 10", {interrupt, int_start});
        end
        tick();
        n_checks++; if ({interrupt, int_start} !== 2'b10) begin
            n_fail++; $display("FAIL lat_assert_e5: got %b want 10", {interrupt, int_start});
        end
        irq_in = 1'b0;
        tick();
        n_checks++; if ({interrupt, int_busy} !== 2'b01) begin
            n_fail++; $display("FAIL lat_service_e6: got %b want 01", {interrupt, int_busy});
        end
        repeat (3) tick();
        n_checks++; if ({interrupt, int_busy} !== 2'b01) begin
            n_fail++; $display("FAIL service_hold: got %b want 01", {interrupt, int_busy});
        end
        rti_done = 1'b1; tick(); rti_done = 1'b0;
        n_checks++; if ({int_busy, pending} !== 2'b00) begin
            n_fail++; $display("FAIL rti_to_idle: got %b want 00", {int_busy, pending});
        end
    endtask

    task automatic test_stall_flush();
        stall = 1'b1; irq_in = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if ({pending, interrupt} !== 2'b10) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got %b want 10", i,
                                   {pending, interrupt});
            end
            tick();
        end
        n_checks++; if ({pending, interrupt} !== 2'b10) begin
            n_fail++; $display("FAIL stall_hold[4]: got %b want 10", {pending, interrupt});
        end
        stall = 1'b0;
        tick();
        n_checks++; if ({interrupt, int_start, pending} !== 3'b110) begin
            n_fail++; $display("FAIL stall_release: got %b want 110",
                               {interrupt, int_start, pending});
        end
        irq_in = 1'b0;
        retire();
        n_checks++; if (int_busy !== 1'b0) begin
            n_fail++; $display("FAIL stall_retire: got %b want 0", int_busy);
        end
        irq_in = 1'b1;
        repeat (3) tick();
        flush = 1'b1;
        tick();
        n_checks++; if ({pending, interrupt} !== 2'b10) begin
            n_fail++; $display("FAIL flush_defer: got %b want 10", {pending, interrupt});
        end
        flush = 1'b0;
        tick();
        n_checks++; if ({interrupt, int_start} !== 2'b11) begin
            n_fail++; $display("FAIL flush_release: got %b want 11", {interrupt, int_start});
        end
        irq_in = 1'b0;
        retire();
        n_checks++; if (int_busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_retire: got %b want 0", int_busy);
        end
    endtask

    task automatic test_lost_edges();
        int n_int;
        irq_in = 1'b1;
        repeat (3) tick();
        irq_in = 1'b0;
        tick();
        irq_in = 1'b1;
        tick(); tick();
        n_checks++; if (interrupt !== 1'b1) begin
            n_fail++; $display("FAIL lost_assert_e5: got %b want 1", interrupt);
        end
        irq_in = 1'b0;
        n_int = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) irq_in = 1'b1;
            tick();
            if (interrupt) n_int++;
        end
        n_checks++; if ({n_int, pending, int_busy} !== {32'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL lost_no_retrigger: got int=%0d pend=%b busy=%b want 0 0 1",
                               n_int, pending, int_busy);
        end
`ifdef IRQ_DROP_COUNT_EN
        n_checks++; if (drop_count !== 8'd2) begin
            n_fail++; $display("FAIL drop_two: got %0d want 2", drop_count);
        end
`endif
        irq_in = 1'b0;
        repeat (3) tick();
        rti_done = 1'b1; tick(); rti_done = 1'b0;
        n_checks++; if ({int_busy, pending} !== 2'b00) begin
            n_fail++; $display("FAIL lost_rti: got %b want 00", {int_busy, pending});
        end
        // Saturation: ~310 edges lost while in SERVICE.
        irq_in = 1'b1;
        repeat (3) tick();
        irq_in = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < 620; i++) begin
            irq_in = ~irq_in;
            tick();
        end
        n_checks++; if ({interrupt, int_busy} !== 2'b01) begin
            n_fail++; $display("FAIL sat_state: got %b want 01", {interrupt, int_busy});
        end
`ifdef IRQ_DROP_COUNT_EN
        n_checks++; if (drop_count !== 8'd255) begin
            n_fail++; $display("FAIL drop_saturate: got %0d want 255", drop_count);
        end
`endif
        irq_in = 1'b0;
        repeat (3) tick();
        rti_done = 1'b1; tick(); rti_done = 1'b0;
    endtask

    task automatic test_rti_edge_coincide();
        rti_done = 1'b1; tick(); rti_done = 1'b0; tick();
        n_checks++; if ({interrupt, pending, int_busy} !== 3'b000) begin
            n_fail++; $display("FAIL rti_in_idle: got %b want 000",
                               {interrupt, pending, int_busy});
        end
        irq_in = 1'b1;
        repeat (3) tick();
        irq_in = 1'b0;
        repeat (4) tick();
        n_checks++; if ({interrupt, int_busy} !== 2'b01) begin
            n_fail++; $display("FAIL coincide_service: got %b want 01", {interrupt, int_busy});
        end
        irq_in = 1'b1;
        tick(); tick();
        n_checks++; if (pending !== 1'b0) begin
            n_fail++; $display("FAIL coincide_pre: got %b want 0", pending);
        end
        rti_done = 1'b1;
        tick();
        rti_done = 1'b0;
        n_checks++; if ({pending, int_busy} !== 2'b10) begin
            n_fail++; $display("FAIL coincide_pending: got %b want 10", {pending, int_busy});
        end
        tick();
        n_checks++; if ({interrupt, int_start} !== 2'b11) begin
            n_fail++; $display("FAIL coincide_launch: got %b want 11", {interrupt, int_start});
        end
        irq_in = 1'b0;
        retire();
    endtask

    task automatic test_reset_mid_assert();
        int n_int, n_start;
        irq_in = 1'b1;
        repeat (4) tick();
        n_checks++; if (interrupt !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_assert: got %b want 1", interrupt);
        end
        rst = 1'b0;
        tick();
        n_checks++; if ({interrupt, int_start, pending, int_busy} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_mid_assert: got %b want 0000",
                               {interrupt, int_start, pending, int_busy});
        end
`ifdef IRQ_DROP_COUNT_EN
        n_checks++; if (drop_count !== 8'd0) begin
            n_fail++; $display("FAIL rst_drop_clear: got %0d want 0", drop_count);
        end
`endif
        rst = 1'b1;
        tick(); tick();
        n_checks++; if (pending !== 1'b0) begin
            n_fail++; $display("FAIL rst_relaunch_e1: got %b want 0", pending);
        end
        tick();
        n_checks++; if (pending !== 1'b1) begin
            n_fail++; $display("FAIL rst_relaunch_e2: got %b want 1", pending);
        end
        n_int = 0; n_start = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (interrupt) n_int++;
            if (int_start) n_start++;
        end
        n_checks++; if ({n_int, n_start} !== {32'd3, 32'd1}) begin
            n_fail++; $display("FAIL rst_one_interrupt: got int=%0d start=%0d want 3 1",
                               n_int, n_start);
        end
        irq_in = 1'b0;
        rti_done = 1'b1; tick(); rti_done = 1'b0;
    endtask

    initial begin
        test_reset_and_latency();
        test_stall_flush();
        test_lost_edges();
        test_rti_edge_coincide();
        test_reset_mid_assert();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
